cnn_rlt_serializer: RTL

- Sits directly downstream of the cnn top-level result port and consumes its `str_rlt_bus` / `str_rlt_val` / `str_rlt_rdy` stream.
- Each accepted result word holds GROUP_NB lanes of IMG_WIDTH bits. The block applies an optional ReLU per lane and emits the lanes OUT_LANES at a time on a narrower output stream.
- It marks the final beat of each result frame of cfg_words words, so the DMA/host side can frame layer outputs.

---
 rtl/cnn_rlt_serializer_if.sv | 28 ++
 rtl/cnn_rlt_serializer.sv | 97 +++++++++
 2 files changed

// File: rtl/cnn_rlt_serializer_if.sv
// Stream bundle around the serializer: wide cnn result words in, narrow lane beats out.
// The slave view belongs to the serializer and the master view to whatever drives and consumes it.
interface cnn_rlt_serializer_if #(
    parameter int unsigned STR_RLT_WIDTH = 64,
    parameter int unsigned OUT_WIDTH     = 16
);
    logic [STR_RLT_WIDTH-1:0] str_rlt_bus;
    logic                     str_rlt_val;
    logic                     str_rlt_rdy;
    logic [OUT_WIDTH-1:0]     str_out_bus;
    logic                     str_out_val;
    logic                     str_out_rdy;
    logic                     str_out_last;

    modport master (
        output str_rlt_bus, str_rlt_val,
        input  str_rlt_rdy,
        input  str_out_bus, str_out_val, str_out_last,
        output str_out_rdy
    );

    modport slave (
        input  str_rlt_bus, str_rlt_val,
        output str_rlt_rdy,
        output str_out_bus, str_out_val, str_out_last,
        input  str_out_rdy
    );
endinterface

// File: rtl/cnn_rlt_serializer.sv
// Splits each cnn result word into OUT_LANES-wide beats, with an optional ReLU applied at capture,
// and flags the last beat of every cfg_words-word frame.
module cnn_rlt_serializer #(
    parameter int unsigned STR_RLT_WIDTH = 64,
    parameter int unsigned GROUP_NB      = 4,
    parameter int unsigned IMG_WIDTH     = 16,
    parameter int unsigned OUT_LANES     = 1,
    parameter int unsigned CNT_WIDTH     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_relu,
    input  logic [CNT_WIDTH-1:0] cfg_words,
    cnn_rlt_serializer_if.slave  str
);
    localparam int unsigned BEATS  = GROUP_NB / OUT_LANES;
    localparam int unsigned OUT_W  = OUT_LANES * IMG_WIDTH;
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic {S_EMPTY, S_FULL} state_t;

    state_t                   r_state;
    logic [STR_RLT_WIDTH-1:0] r_hold;
    logic [BEAT_W-1:0]        r_beat;
    logic [CNT_WIDTH-1:0]     r_wcnt;

    logic [STR_RLT_WIDTH-1:0] w_relu_word;
    logic [OUT_W-1:0]         w_beat_data;
    logic                     w_full;
    logic                     w_last_beat;
    logic                     w_out_xfer;
    logic                     w_in_xfer;
    logic                     w_frame_end;
    logic                     w_wcnt_wrap;

    assign w_full      = (r_state == S_FULL);
    assign w_last_beat = w_full && (r_beat == LAST_BEAT);
    assign w_out_xfer  = w_full && str.str_out_rdy;
    assign w_frame_end = (cfg_words != '0) && (r_wcnt == cfg_words - CNT_WIDTH'(1));
    // >= rather than == so a mid-frame shrink of cfg_words still wraps instead of running away
    assign w_wcnt_wrap = (cfg_words == '0) || (r_wcnt >= cfg_words - CNT_WIDTH'(1));

    // Ready looks through to the downstream handshake so a new word can land on the last beat.
    assign str.str_rlt_rdy  = !rst && (!w_full || (w_out_xfer && w_last_beat));
    assign w_in_xfer        = str.str_rlt_val && str.str_rlt_rdy;
    assign str.str_out_val  = w_full;
    assign str.str_out_bus  = w_beat_data;
    assign str.str_out_last = w_last_beat && w_frame_end;

    always_comb begin
        w_relu_word = str.str_rlt_bus;
        if (cfg_relu) begin
            for (int unsigned i = 0; i < GROUP_NB; i++) begin
                if (str.str_rlt_bus[i*IMG_WIDTH + IMG_WIDTH - 1]) begin
                    w_relu_word[i*IMG_WIDTH +: IMG_WIDTH] = '0;
                end
            end
        end
    end

    always_comb begin
        w_beat_data = '0;
        if (w_full) begin
            for (int unsigned b = 0; b < BEATS; b++) begin
                if (r_beat == BEAT_W'(b)) begin
                    w_beat_data = r_hold[b*OUT_W +: OUT_W];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_EMPTY;
            r_hold  <= '0;
            r_beat  <= '0;
            r_wcnt  <= '0;
        end else begin
            if (w_out_xfer && w_last_beat) begin
                r_wcnt <= w_wcnt_wrap ? '0 : r_wcnt + CNT_WIDTH'(1);
            end
            if (w_in_xfer) begin
                r_hold  <= w_relu_word;
                r_beat  <= '0;
                r_state <= S_FULL;
            end else if (w_out_xfer) begin
                if (w_last_beat) begin
                    r_beat  <= '0;
                    r_state <= S_EMPTY;
                end else begin
                    r_beat <= r_beat + BEAT_W'(1);
                end
            end
        end
    end
endmodule
